mat_mult_sched: RTL and testbench

- Sequencer that computes C = A x B for two NxN matrices of unsigned 8-bit elements, using one shared external 8x8 combinational multiplier.
- Operands are loaded into internal register files through a write port.
- The block time-multiplexes the multiplier, issuing one product per cycle, and accumulates each dot product.
- Each C element is streamed out on a valid/ready interface in row-major order.
- It sits between the host load logic and the multiplier datapath of the matrix-multiply unit.

---
 rtl/mat_mult_sched.sv | 153 +++++++++++++++
 tb/tb_mat_mult_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_sched.sv
// mat_mult_sched: sequences C = A x B for NxN unsigned 8-bit matrices through
// one shared external combinational 8x8 multiplier, one product per cycle,
// and streams each C element out in row-major order on a valid/ready port.
module mat_mult_sched #(
    parameter int N     = 2,
    parameter int ACC_W = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_en,
    input  logic                     ld_sel,
    input  logic [$clog2(N*N)-1:0]   ld_addr,
    input  logic [7:0]               ld_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               mul_a,
    output logic [7:0]               mul_b,
    input  logic [15:0]              mul_c,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_data,
    output logic [$clog2(N)-1:0]     res_row,
    output logic [$clog2(N)-1:0]     res_col
);

    localparam int AW = $clog2(N*N);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_reg;
    logic [IW-1:0]    i_reg;
    logic [IW-1:0]    j_reg;
    logic [IW-1:0]    k_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             valid_reg;

    logic [7:0]       a_mem [N*N];
    logic [7:0]       b_mem [N*N];
    logic [N*N-1:0]   wr_hit;
    logic [AW-1:0]    a_idx;
    logic [AW-1:0]    b_idx;

    // Per-element write decode; addresses at or beyond N*N match no element.
    for (genvar gi = 0; gi < N*N; gi++) begin : g_wr_dec
        assign wr_hit[gi] = ld_en && (state_reg == S_IDLE) && (ld_addr == AW'(gi));
    end

    // Operand storage: writable only in IDLE, cleared by reset, kept across runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < N*N; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < N*N; e++) begin
                if (wr_hit[e]) begin
                    if (ld_sel) b_mem[e] <= ld_data;
                    else        a_mem[e] <= ld_data;
                end
            end
        end
    end

    // A[i][k] and B[k][j] addresses from the registered loop indices.
    assign a_idx = AW'(int'(i_reg) * N + int'(k_reg));
    assign b_idx = AW'(int'(k_reg) * N + int'(j_reg));

    assign mul_a = (state_reg == S_MAC) ? a_mem[a_idx] : 8'd0;
    assign mul_b = (state_reg == S_MAC) ? b_mem[b_idx] : 8'd0;

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign res_valid = valid_reg;
    assign res_data  = acc_reg;
    assign res_row   = i_reg;
    assign res_col   = j_reg;

    // Control FSM: walks i/j over the result grid and k over each dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= S_MAC;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                S_MAC: begin
                    // First product of a dot product restarts the sum.
                    if (k_reg == '0) acc_reg <= ACC_W'(mul_c);
                    else             acc_reg <= acc_reg + ACC_W'(mul_c);
                    if (k_reg == LAST) begin
                        k_reg     <= '0;
                        state_reg <= S_OUT;
                        valid_reg <= 1'b1;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        valid_reg <= 1'b0;
                        if (i_reg == LAST && j_reg == LAST) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_MAC;
                            if (j_reg == LAST) begin
                                j_reg <= '0;
                                i_reg <= i_reg + 1'b1;
                            end else begin
                                j_reg <= j_reg + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Testbench for mat_mult_sched (N=2): a matrix-product model predicts the
// result stream; a negedge compare process checks every presented result.
module tb_mat_mult_sched;

    localparam int N     = 2;
    localparam int ACC_W = 17;

    logic             clk;
    logic             rst_n;
    logic             ld_en;
    logic             ld_sel;
    logic [1:0]       ld_addr;
    logic [7:0]       ld_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [15:0]      mul_c;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [0:0]       res_row;
    logic [0:0]       res_col;

    mat_mult_sched #(.N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .busy(busy),
        .done(done), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    // External combinational multiplier.
    assign mul_c = 16'(mul_a) * 16'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     row;
        int     col;
    } res_t;

    res_t   exp_q[$];
    longint got[$];
    int     ma[4];
    int     mb[4];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     start_cyc = 0;
    int     first_hs, last_hs, done_cyc, done_cnt, stall_cnt;
    bit     chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every presented result must match the model queue head.
    initial forever begin
        @(negedge clk);
        if (chk_en && rst_n) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_result actual=%0d required=none", res_data);
                end else begin
                    check("res_data", res_data, exp_q[0].data);
                    check("res_row", res_row, exp_q[0].row);
                    check("res_col", res_col, exp_q[0].col);
                    check("mul_a_in_out", mul_a, 0);
                    check("mul_b_in_out", mul_b, 0);
                    if (res_ready) begin
                        got.push_back(res_data);
                        if (first_hs < 0) first_hs = cyc + 1 - start_cyc;
                        last_hs = cyc + 1 - start_cyc;
                        void'(exp_q.pop_front());
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
                check("done_all_results_out", exp_q.size(), 0);
            end
        end
    end

    task automatic load(input bit sel, input int addr, input int data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = 2'(addr);
        ld_data = 8'(data);
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    task automatic wait_res(input int r, input int c, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (res_valid && res_row == 1'(r) && res_col == 1'(c)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("wait_res_timeout", ok, 1);
    endtask

    // mode: 0 plain, 1 backpressure, 2 ignored inputs, 3 reset mid-run, 4 multiplier drive
    task automatic run(input int mode, input longint lit[4]);
        bit ok;
        got.delete();
        first_hs  = -1;
        last_hs   = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        stall_cnt = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                res_t r;
                longint s = 0;
                for (int k = 0; k < N; k++) s += longint'(ma[i*N+k]) * longint'(mb[k*N+j]);
                r.data = s & ((64'd1 << ACC_W) - 1);
                r.row  = i;
                r.col  = j;
                exp_q.push_back(r);
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        ld_en     = 1'b0;
        start_cyc = cyc;

        if (mode == 1) begin
            wait_res(0, 0, ok);
            @(posedge clk); #1;
            res_ready = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            repeat (4) begin @(posedge clk); #1; end
            res_ready = 1'b1;
        end else if (mode == 2) begin
            repeat (4) begin @(posedge clk); #1; end
            start   = 1'b1;
            ld_en   = 1'b1;
            ld_sel  = 1'b0;
            ld_addr = 2'd0;
            ld_data = 8'd99;
            @(posedge clk); #1;
            start = 1'b0;
            ld_en = 1'b0;
        end else if (mode == 3) begin
            wait_res(0, 1, ok);
            @(posedge clk); #1;
            chk_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check("async_rst_busy", busy, 0);
            check("async_rst_done", done, 0);
            check("async_rst_valid", res_valid, 0);
            check("async_rst_data", res_data, 0);
            check("async_rst_row", res_row, 0);
            check("async_rst_col", res_col, 0);
            check("async_rst_mul_a", mul_a, 0);
            check("async_rst_mul_b", mul_b, 0);
            exp_q.delete();
            for (int e = 0; e < 4; e++) begin
                ma[e] = 0;
                mb[e] = 0;
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("post_rst_busy", busy, 0);
            check("post_rst_valid", res_valid, 0);
            chk_en = 1'b1;
            return;
        end else if (mode == 4) begin
            wait_res(1, 0, ok);
            @(posedge clk); #1;
            check("mul_a_k0", mul_a, 3);
            check("mul_b_k0", mul_b, 6);
            @(posedge clk); #1;
            check("mul_a_k1", mul_a, 4);
            check("mul_b_k1", mul_b, 8);
        end

        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_timeout", ok, 1);
        if (mode == 2) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (mode == 2) check("start_in_done_ignored", busy, 0);
        check("done_pulses", done_cnt, 1);
        check("done_low_after", done, 0);
        check("result_count", got.size(), 4);
        for (int e = 0; e < 4; e++) begin
            if (e < got.size()) check($sformatf("lit_result_%0d", e), got[e], lit[e]);
        end
        if (mode == 1) begin
            check("stall_cycles", stall_cnt, 4);
            check("last_hs_stalled", last_hs, 16);
        end else begin
            check("first_hs_cycle", first_hs, 3);
            check("last_hs_cycle", last_hs, 12);
            check("done_cycle", done_cyc, 12);
        end
        $display("run mode=%0d results=%0d,%0d,%0d,%0d last_hs=%0d", mode,
                 (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1,
                 (got.size() > 2) ? got[2] : -1, (got.size() > 3) ? got[3] : -1, last_hs);
    endtask

    task automatic load_basic();
        for (int e = 0; e < 4; e++) load(1'b0, e, e + 1);
        for (int e = 0; e < 4; e++) load(1'b1, e, e + 5);
    endtask

    initial begin
        longint basic[4] = '{19, 22, 43, 50};
        longint maxv[4]  = '{130050, 130050, 130050, 130050};
        longint zero[4]  = '{0, 0, 0, 0};
        rst_n = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; res_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin ma[e] = 0; mb[e] = 0; end
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", res_valid, 0);
        check("reset_data", res_data, 0);
        check("reset_mul_a", mul_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        load_basic();
        run(0, basic);
        run(4, basic);
        run(1, basic);
        run(2, basic);
        run(0, basic);

        // All-255 operands; last B element written in the same cycle as start.
        for (int e = 0; e < 4; e++) load(1'b0, e, 255);
        for (int e = 0; e < 3; e++) load(1'b1, e, 255);
        ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 2'd3; ld_data = 8'd255;
        mb[3] = 255;
        run(0, maxv);

        load_basic();
        run(3, zero);
        run(0, zero);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
